// File: rtl/riscv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_pkg : shared RV32IM execute-stage encodings and helpers -- Rev 1.0
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] FWD_RD   = 2'b00;
  localparam logic [1:0] FWD_RESW = 2'b01;
  localparam logic [1:0] FWD_ALUM = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_M1   = 2'd1,
    ST_M2   = 2'd2
  } mul_state_e;

  // Select 11 falls back to the register-file value.
  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] rd,
                                          input logic [31:0] resw, input logic [31:0] alum);
    case (sel)
      FWD_RESW: fwd_mux = resw;
      FWD_ALUM: fwd_mux = alum;
      default:  fwd_mux = rd;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu : combinational RV32I ALU, unused op codes yield zero -- Rev 1.0
// ---------------------------------------------------------------------------
module alu
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ALUControl,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (ALUControl)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'd0, a < b};
      ALU_SLL:   result = a << b[4:0];
      ALU_SRL:   result = a >> b[4:0];
      ALU_SRA:   result = $signed(a) >>> b[4:0];
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ex_stage : RV32IM execute stage (ID/EX reg, forwarding, ALU, branch, MUL) -- Rev 1.0
// ---------------------------------------------------------------------------
module ex_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        JalrD,
  input  logic        ALUSrcD,
  input  logic        MulD,
  input  logic [1:0]  ResultSrcD,
  input  logic [3:0]  ALUControlD,
  input  logic [2:0]  funct3D,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rdD,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] PCD,
  input  logic [31:0] ImmExtD,
  input  logic [31:0] PCplus4D,
  input  logic        FlushE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  input  logic [31:0] ALUResultM,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic [1:0]  ResultSrcE,
  output logic [4:0]  rdE,
  output logic [4:0]  rs1E,
  output logic [4:0]  rs2E,
  output logic [31:0] PCplus4E,
  output logic [31:0] ALUResultE,
  output logic [31:0] SrcBE,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        BusyE
);

  logic        regwrite_q, memwrite_q, branch_q, jump_q, jalr_q, alusrc_q, mul_q;
  logic [1:0]  resultsrc_q;
  logic [3:0]  aluctl_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [31:0] rd1_q, rd2_q, pc_q, imm_q, pcplus4_q;

  mul_state_e  state_q, state_d;
  logic [31:0] opa_q, opb_q, prod_q;

  logic [31:0] src_a, write_data, alu_b, alu_res, tgt_sum;
  logic        br_cond, busy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_q) state_d = ST_M1;
      ST_M1:   state_d = ST_M2;
      ST_M2:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The instruction stays in EX as long as the sequencer will not be idle next cycle.
  assign busy = (state_d != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      jalr_q      <= 1'b0;
      alusrc_q    <= 1'b0;
      mul_q       <= 1'b0;
      resultsrc_q <= 2'd0;
      aluctl_q    <= 4'd0;
      funct3_q    <= 3'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      rd1_q       <= 32'd0;
      rd2_q       <= 32'd0;
      pc_q        <= 32'd0;
      imm_q       <= 32'd0;
      pcplus4_q   <= 32'd0;
    end else if (!busy) begin
      regwrite_q  <= RegWriteD & ~FlushE;
      memwrite_q  <= MemWriteD & ~FlushE;
      branch_q    <= BranchD & ~FlushE;
      jump_q      <= JumpD & ~FlushE;
      jalr_q      <= JalrD & ~FlushE;
      mul_q       <= MulD & ~FlushE;
      rd_q        <= FlushE ? 5'd0 : rdD;
      alusrc_q    <= ALUSrcD;
      resultsrc_q <= ResultSrcD;
      aluctl_q    <= ALUControlD;
      funct3_q    <= funct3D;
      rs1_q       <= rs1D;
      rs2_q       <= rs2D;
      rd1_q       <= RD1D;
      rd2_q       <= RD2D;
      pc_q        <= PCD;
      imm_q       <= ImmExtD;
      pcplus4_q   <= PCplus4D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      prod_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && mul_q) begin
        opa_q <= src_a;
        opb_q <= write_data;
      end
      if (state_q == ST_M1) prod_q <= opa_q * opb_q;
    end
  end

  assign src_a      = fwd_mux(ForwardAE, rd1_q, ResultW, ALUResultM);
  assign write_data = fwd_mux(ForwardBE, rd2_q, ResultW, ALUResultM);
  assign alu_b      = alusrc_q ? imm_q : write_data;

  alu u_alu (
    .a          (src_a),
    .b          (alu_b),
    .ALUControl (aluctl_q),
    .result     (alu_res)
  );

  always_comb begin
    br_cond = 1'b0;
    case (funct3_q)
      F3_BEQ:  br_cond = (src_a == write_data);
      F3_BNE:  br_cond = (src_a != write_data);
      F3_BLT:  br_cond = ($signed(src_a) < $signed(write_data));
      F3_BGE:  br_cond = ($signed(src_a) >= $signed(write_data));
      F3_BLTU: br_cond = (src_a < write_data);
      F3_BGEU: br_cond = (src_a >= write_data);
      default: br_cond = 1'b0;
    endcase
  end

  assign tgt_sum    = (jalr_q ? src_a : pc_q) + imm_q;
  assign PCTargetE  = {tgt_sum[31:1], tgt_sum[0] & ~jalr_q};
  assign PCSrcE     = ~mul_q & (jump_q | (branch_q & br_cond));

  assign BusyE      = busy;
  assign RegWriteE  = regwrite_q & ~busy;
  assign MemWriteE  = memwrite_q & ~busy;
  assign ResultSrcE = resultsrc_q;
  assign rdE        = rd_q;
  assign rs1E       = rs1_q;
  assign rs2E       = rs2_q;
  assign PCplus4E   = pcplus4_q;
  assign SrcBE      = write_data;
  assign ALUResultE = (state_q == ST_M2) ? prod_q : alu_res;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ex_stage : scoreboard bench for ex_stage with random and directed traffic -- Rev 1.0
// ---------------------------------------------------------------------------
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteD, MemWriteD, BranchD, JumpD, JalrD, ALUSrcD, MulD;
  logic [1:0]  ResultSrcD;
  logic [3:0]  ALUControlD;
  logic [2:0]  funct3D;
  logic [4:0]  rs1D, rs2D, rdD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCplus4D;
  logic        FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW, ALUResultM;
  logic        RegWriteE, MemWriteE, PCSrcE, BusyE;
  logic [1:0]  ResultSrcE;
  logic [4:0]  rdE, rs1E, rs2E;
  logic [31:0] PCplus4E, ALUResultE, SrcBE, PCTargetE;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
    .JalrD(JalrD), .ALUSrcD(ALUSrcD), .MulD(MulD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .funct3D(funct3D), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCplus4D(PCplus4D),
    .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .ALUResultM(ALUResultM),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .rdE(rdE), .rs1E(rs1E), .rs2E(rs2E), .PCplus4E(PCplus4E), .ALUResultE(ALUResultE),
    .SrcBE(SrcBE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE)
  );

  typedef struct {
    string       name;
    logic        rw, mw, br, jmp, jalr, alusrc, mul, flush;
    logic [1:0]  rsrc, fa, fb;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, pc, imm, pc4, resw, alum;
  } txn_t;

  typedef struct {
    string       name;
    logic        flush, rw, mw, pcsrc, chk_srcb, chk_tgt;
    logic [1:0]  rsrc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc4, res, srcb, tgt;
    int          busy;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ext;
    logic        slt;
    slt = (a[31] != b[31]) ? a[31] : (a < b);
    ext = {{32{a[31]}}, a} >> b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return {31'd0, slt};
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return ext[31:0];
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r,
                                       input logic [31:0] w, input logic [31:0] m);
    return (s == 2'd1) ? w : (s == 2'd2) ? m : r;
  endfunction

  function automatic exp_t model(input txn_t t);
    exp_t        e;
    logic [31:0] a, wd, b;
    logic [63:0] prod;
    logic        taken;
    a  = pick(t.fa, t.rd1, t.resw, t.alum);
    wd = pick(t.fb, t.rd2, t.resw, t.alum);
    b  = t.alusrc ? t.imm : wd;
    e = '{name: t.name, flush: t.flush, rw: 1'b0, mw: 1'b0, pcsrc: 1'b0, chk_srcb: 1'b0,
          chk_tgt: 1'b0, rsrc: t.rsrc, rs1: t.rs1, rs2: t.rs2, rd: 5'd0, pc4: t.pc4,
          res: 32'd0, srcb: wd, tgt: 32'd0, busy: 0};
    if (!t.flush) begin
      e.rw = t.rw;
      e.mw = t.mw;
      e.rd = t.rd;
      if (t.mul) begin
        prod   = {32'd0, a} * {32'd0, wd};
        e.res  = prod[31:0];
        e.busy = 2;
      end else begin
        e.res = ref_alu(t.op, a, b);
        e.chk_srcb = 1'b1;
        e.chk_tgt  = 1'b1;
        case (t.f3)
          3'b000:  taken = (a == wd);
          3'b001:  taken = (a != wd);
          3'b100:  taken = ($signed(a) < $signed(wd));
          3'b101:  taken = !($signed(a) < $signed(wd));
          3'b110:  taken = (a < wd);
          3'b111:  taken = !(a < wd);
          default: taken = 1'b0;
        endcase
        e.pcsrc = t.jmp || (t.br && taken);
        e.tgt   = (t.jalr ? a : t.pc) + t.imm;
        if (t.jalr) e.tgt[0] = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic txn_t blank(input string nm);
    txn_t t;
    t = '{name: nm, rw: 0, mw: 0, br: 0, jmp: 0, jalr: 0, alusrc: 0, mul: 0, flush: 0,
          rsrc: 0, fa: 0, fb: 0, op: 0, f3: 3'b010, rs1: 5'd1, rs2: 5'd2, rd: 5'd3,
          rd1: 0, rd2: 0, pc: 32'h100, imm: 0, pc4: 32'h104, resw: 0, alum: 0};
    return t;
  endfunction

  function automatic txn_t rand_txn(input int idx);
    txn_t t;
    t = blank($sformatf("rnd%0d", idx));
    t.rw = 1'($urandom); t.mw = 1'($urandom); t.br = ($urandom_range(0, 2) == 0);
    t.jmp = ($urandom_range(0, 5) == 0); t.jalr = t.jmp && 1'($urandom);
    t.alusrc = 1'($urandom); t.flush = ($urandom_range(0, 7) == 0);
    t.mul = ($urandom_range(0, 5) == 0);
    t.rsrc = 2'($urandom); t.fa = 2'($urandom); t.fb = 2'($urandom);
    t.op = 4'($urandom); t.f3 = 3'($urandom);
    t.rs1 = 5'($urandom); t.rs2 = 5'($urandom); t.rd = 5'($urandom);
    t.rd1 = $urandom; t.rd2 = $urandom; t.pc = $urandom; t.imm = $urandom;
    t.pc4 = $urandom; t.resw = $urandom; t.alum = $urandom;
    if ($urandom_range(0, 3) == 0) t.rd2 = t.rd1;
    if (t.mul) begin
      t.br = 0; t.jmp = 0; t.jalr = 0; t.alusrc = 0;
    end
    return t;
  endfunction

  task automatic drive_d(input txn_t t);
    RegWriteD = t.rw; MemWriteD = t.mw; BranchD = t.br; JumpD = t.jmp; JalrD = t.jalr;
    ALUSrcD = t.alusrc; MulD = t.mul; ResultSrcD = t.rsrc; ALUControlD = t.op;
    funct3D = t.f3; rs1D = t.rs1; rs2D = t.rs2; rdD = t.rd; RD1D = t.rd1; RD2D = t.rd2;
    PCD = t.pc; ImmExtD = t.imm; PCplus4D = t.pc4; FlushE = t.flush;
  endtask

  // One instruction through EX; returns just after the edge into its result cycle.
  task automatic run(input txn_t t);
    drive_d(t);
    @(posedge clk); #1;
    ForwardAE = t.fa; ForwardBE = t.fb; ResultW = t.resw; ALUResultM = t.alum;
    sbq.push_back(model(t));
    if (t.mul && !t.flush) begin
      @(posedge clk); #1;
      ResultW = $urandom; ALUResultM = $urandom;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".busy"}, {31'd0, BusyE}, 32'd0);
    chk({tag, ".ctl"}, {28'd0, RegWriteE, MemWriteE, PCSrcE, 1'b0}, 32'd0);
    chk({tag, ".rsrc"}, {30'd0, ResultSrcE}, 32'd0);
    chk({tag, ".rd"}, {27'd0, rdE}, 32'd0);
    chk({tag, ".alures"}, ALUResultE, 32'd0);
    chk({tag, ".srcb"}, SrcBE, 32'd0);
    chk({tag, ".tgt"}, PCTargetE, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (BusyE) begin
          busy_cnt++;
          chk("busy_bubble", {30'd0, RegWriteE, MemWriteE}, 32'd0);
        end else if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk({e.name, ".busy"}, busy_cnt, e.busy);
          busy_cnt = 0;
          chk({e.name, ".rw_mw"}, {30'd0, RegWriteE, MemWriteE}, {30'd0, e.rw, e.mw});
          chk({e.name, ".rd"}, {27'd0, rdE}, {27'd0, e.rd});
          chk({e.name, ".pcsrc"}, {31'd0, PCSrcE}, {31'd0, e.pcsrc});
          if (!e.flush) begin
            chk({e.name, ".res"}, ALUResultE, e.res);
            chk({e.name, ".pc4"}, PCplus4E, e.pc4);
            chk({e.name, ".rsrc_rs"}, {17'd0, ResultSrcE, rs1E, rs2E},
                {17'd0, e.rsrc, e.rs1, e.rs2});
          end
          if (e.chk_srcb) chk({e.name, ".srcb"}, SrcBE, e.srcb);
          if (e.chk_tgt)  chk({e.name, ".tgt"}, PCTargetE, e.tgt);
        end
      end
    end
  end

  initial begin : stimulus
    txn_t t;
    reset = 1'b1;
    drive_d(blank("idle"));
    FlushE = 1'b0; ForwardAE = 2'd0; ForwardBE = 2'd0; ResultW = 32'd0; ALUResultM = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    t = blank("add_fwd"); t.rd1 = 32'd5; t.fa = 2'd2; t.alum = 32'h10; t.imm = 32'd3;
    t.alusrc = 1; t.op = 4'd0; t.rw = 1; t.rd = 5'd5;
    run(t);
    t = blank("blt"); t.br = 1; t.f3 = 3'b100; t.fa = 2'd1; t.resw = 32'hFFFF_FFFF;
    t.rd2 = 32'd1; t.imm = 32'h20;
    run(t);
    t.name = "bltu"; t.f3 = 3'b110;
    run(t);
    t = blank("jalr"); t.jmp = 1; t.jalr = 1; t.rd1 = 32'h1001; t.imm = 32'd4;
    t.rw = 1; t.rd = 5'd1; t.rsrc = 2'd2;
    run(t);
    t = blank("mul_7x6"); t.mul = 1; t.rd1 = 32'd7; t.fb = 2'd1; t.resw = 32'd6;
    t.rw = 1; t.rd = 5'd10;
    run(t);
    t = blank("mul_neg1x2"); t.mul = 1; t.rd1 = 32'hFFFF_FFFF; t.rd2 = 32'd2;
    t.rw = 1; t.rd = 5'd11;
    run(t);
    t = blank("flush_st"); t.mw = 1; t.flush = 1; t.rd = 5'd7; t.alusrc = 1;
    run(t);
    t = blank("store"); t.mw = 1; t.fb = 2'd1; t.resw = 32'hDEAD; t.rd1 = 32'h2000;
    t.imm = 32'd8; t.alusrc = 1; t.op = 4'd0;
    run(t);

    for (int i = 0; i < 120; i++) run(rand_txn(i));

    drive_d(blank("idle"));
    FlushE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("sb_drained", sbq.size(), 32'd0);

    t = blank("mul_rst"); t.mul = 1; t.rd1 = 32'd3; t.rd2 = 32'd5; t.rw = 1; t.rd = 5'd9;
    drive_d(t);
    FlushE = 1'b0; ForwardAE = 2'd0; ForwardBE = 2'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mul_rst.busy_m1", {31'd0, BusyE}, 32'd1);
    reset = 1'b1;
    drive_d(blank("idle"));
    ResultW = 32'd0; ALUResultM = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("mid_mul_reset");
    @(posedge clk); #1;
    chk("post_reset.busy", {31'd0, BusyE}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
